// File: rtl/fpu_result_sink.sv
// ---------------------------------------------------------------------------
// fpu_result_sink
// Consumer end of the FPU result handshake. Accepted results are buffered in
// a DEPTH-entry FIFO and presented to a downstream reader. The block also
// keeps sticky IEEE exception flags, counts accepted results and checks that
// operation tags arrive in increasing order.
//
// Ports:
//   clk_i, rst_ni                  clock (rising edge), synchronous active-low reset
//   res_valid_i/res_ready_o        upstream FPU result handshake
//   res_result_i/status_i/tag_i    upstream payload (status = {NV,DZ,OF,UF,NX})
//   deq_valid_o/deq_ready_i        downstream handshake at the FIFO head
//   deq_result_o/status_o/tag_o    head payload (all zero while empty)
//   clr_i                          clears flags, counters and expected tag
//   fflags_o                       sticky OR of accepted status
//   res_cnt_o, err_cnt_o           accepted-result and tag-mismatch counters
//   tag_err_o                      sticky tag-order mismatch
//   level_o                        FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fpu_result_sink #(
  parameter int DWIDTH    = 16,
  parameter int TAG_WIDTH = 4,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     res_valid_i,
  output logic                     res_ready_o,
  input  logic [DWIDTH-1:0]        res_result_i,
  input  logic [4:0]               res_status_i,
  input  logic [TAG_WIDTH-1:0]     res_tag_i,
  output logic                     deq_valid_o,
  input  logic                     deq_ready_i,
  output logic [DWIDTH-1:0]        deq_result_o,
  output logic [4:0]               deq_status_o,
  output logic [TAG_WIDTH-1:0]     deq_tag_o,
  input  logic                     clr_i,
  output logic [4:0]               fflags_o,
  output logic [CNT_WIDTH-1:0]     res_cnt_o,
  output logic                     tag_err_o,
  output logic [CNT_WIDTH-1:0]     err_cnt_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DWIDTH + 5 + TAG_WIDTH;

  logic [EW-1:0]        mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [4:0]           fflags_q, fflags_d;
  logic [CNT_WIDTH-1:0] res_cnt_q, res_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                 tag_err_q, tag_err_d;
  logic [TAG_WIDTH-1:0] exp_tag_q, exp_tag_d;

  logic                 full_s;
  logic                 empty_s;
  logic                 accept_s;
  logic                 pop_s;
  // Statistics base value: a clear in the same cycle as an accept lets the
  // accept land on top of the cleared state rather than being lost.
  logic [4:0]           fflags_base_s;
  logic [CNT_WIDTH-1:0] res_cnt_base_s;
  logic [CNT_WIDTH-1:0] err_cnt_base_s;
  logic                 tag_err_base_s;
  logic [TAG_WIDTH-1:0] exp_tag_base_s;

  // Ready depends only on registered occupancy, so a pop never frees a slot
  // for a push in the same cycle.
  assign full_s   = (level_q == LW'(DEPTH));
  assign empty_s  = (level_q == {LW{1'b0}});
  assign accept_s = res_valid_i & ~full_s;
  assign pop_s    = ~empty_s & deq_ready_i;

  assign res_ready_o = ~full_s;
  assign deq_valid_o = ~empty_s;
  assign level_o     = level_q;
  assign fflags_o    = fflags_q;
  assign res_cnt_o   = res_cnt_q;
  assign err_cnt_o   = err_cnt_q;
  assign tag_err_o   = tag_err_q;

  // Head data comes straight from storage; forced to zero while empty.
  always_comb begin
    if (empty_s) begin
      {deq_result_o, deq_status_o, deq_tag_o} = {EW{1'b0}};
    end else begin
      {deq_result_o, deq_status_o, deq_tag_o} = mem_q[rd_ptr_q];
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({accept_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Flag, counter and tag-order next-state.
  always_comb begin
    if (clr_i) begin
      fflags_base_s  = 5'b00000;
      res_cnt_base_s = {CNT_WIDTH{1'b0}};
      err_cnt_base_s = {CNT_WIDTH{1'b0}};
      tag_err_base_s = 1'b0;
      exp_tag_base_s = {TAG_WIDTH{1'b0}};
    end else begin
      fflags_base_s  = fflags_q;
      res_cnt_base_s = res_cnt_q;
      err_cnt_base_s = err_cnt_q;
      tag_err_base_s = tag_err_q;
      exp_tag_base_s = exp_tag_q;
    end
    fflags_d  = fflags_base_s;
    res_cnt_d = res_cnt_base_s;
    err_cnt_d = err_cnt_base_s;
    tag_err_d = tag_err_base_s;
    exp_tag_d = exp_tag_base_s;
    if (accept_s) begin
      fflags_d  = fflags_base_s | res_status_i;
      res_cnt_d = res_cnt_base_s + CNT_WIDTH'(1);
      // Expected tag always resyncs to the received tag, so one gap costs
      // exactly one error.
      exp_tag_d = res_tag_i + TAG_WIDTH'(1);
      if (res_tag_i != exp_tag_base_s) begin
        tag_err_d = 1'b1;
        err_cnt_d = err_cnt_base_s + CNT_WIDTH'(1);
      end else begin
        tag_err_d = tag_err_base_s;
        err_cnt_d = err_cnt_base_s;
      end
    end else begin
      fflags_d  = fflags_base_s;
      res_cnt_d = res_cnt_base_s;
    end
  end

  // FIFO storage; reset clears entries so no stale data survives.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
    end else if (accept_s) begin
      mem_q[wr_ptr_q] <= {res_result_i, res_status_i, res_tag_i};
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      level_q   <= {LW{1'b0}};
      fflags_q  <= 5'b00000;
      res_cnt_q <= {CNT_WIDTH{1'b0}};
      err_cnt_q <= {CNT_WIDTH{1'b0}};
      tag_err_q <= 1'b0;
      exp_tag_q <= {TAG_WIDTH{1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      fflags_q  <= fflags_d;
      res_cnt_q <= res_cnt_d;
      err_cnt_q <= err_cnt_d;
      tag_err_q <= tag_err_d;
      exp_tag_q <= exp_tag_d;
    end
  end

endmodule

// File: doc/fpu_result_sink.md
Name: fpu_result_sink

Overview:
Consumer end of the FPU result handshake. It accepts results from the FPU output channel (valid/ready, result, status flags, tag), buffers them in a small FIFO and presents them to a downstream reader. It accumulates sticky IEEE exception flags, counts accepted results and checks that tags arrive in order. It sits between fpu_wrap's output port and the bench monitor or integration logic, and provides real FPU backpressure.

Parameters:
DWIDTH, 16, result width in bits
TAG_WIDTH, 4, width of the operation tag
DEPTH, 4, FIFO entries; power of two, >=2
CNT_WIDTH, 16, width of the result and error counters

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  synchronous active-low reset
res_valid_i  in  1  FPU result valid
res_ready_o  out  1  sink can accept a result
res_result_i  in  DWIDTH  FPU result
res_status_i  in  5  exception flags {NV,DZ,OF,UF,NX}
res_tag_i  in  TAG_WIDTH  operation tag
deq_valid_o  out  1  FIFO head valid
deq_ready_i  in  1  downstream pops head
deq_result_o  out  DWIDTH  head result
deq_status_o  out  5  head status
deq_tag_o  out  TAG_WIDTH  head tag
clr_i  in  1  clear flags, counters and expected tag; FIFO untouched
fflags_o  out  5  sticky OR of accepted status
res_cnt_o  out  CNT_WIDTH  accepted results
tag_err_o  out  1  sticky tag-order mismatch
err_cnt_o  out  CNT_WIDTH  tag mismatches
level_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_ni=0 at clk edge): FIFO empty, rd/wr pointers 0, level_o=0, deq_valid_o=0, res_ready_o=1 in the first cycle after reset; fflags_o=0, res_cnt_o=0, err_cnt_o=0, tag_err_o=0, expected tag=0. deq_result_o/deq_status_o/deq_tag_o are 0 while empty. Reset mid-transfer drops all buffered entries without popping them.
- Accept = res_valid_i & res_ready_o. Pop = deq_valid_o & deq_ready_i.
- res_ready_o = (level_o != DEPTH). It depends only on registered state: no combinational path from deq_ready_i. When full, a same-cycle pop does not free a slot for a push.
- deq_valid_o = (level_o != 0). Head data is driven from the FIFO storage entry at rd pointer.
- Latency: an accepted result is visible on deq_* in the cycle after acceptance. There is no bypass, even when the FIFO is empty.
- Simultaneous accept and pop when 0<level<DEPTH: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. level_o ranges 0..DEPTH.
- Flags: on accept, fflags_o <= fflags_o | res_status_i.
- Counting: on accept, res_cnt_o increments, wrapping modulo 2^CNT_WIDTH.
- Tag check, on accept:
  - If res_tag_i != expected tag: tag_err_o <= 1 and err_cnt_o increments (wraps).
  - In all cases, expected tag <= res_tag_i+1 modulo 2^TAG_WIDTH (resync after a mismatch).
- clr_i=1: fflags_o, res_cnt_o, err_cnt_o, tag_err_o and expected tag are cleared. An accept in the same cycle is then applied on top of the cleared state:
  - fflags_o = res_status_i
  - res_cnt_o = 1
  - mismatch checked against expected tag 0
  - expected tag = res_tag_i+1
- FIFO contents and handshakes are unaffected by clr_i.
- Inputs res_result_i, res_status_i and res_tag_i are don't-care when res_valid_i=0. Upstream must hold its data stable while valid and not ready; the sink does not check this.

Test Plan:
- Reset then idle: after rst_ni low for 2 cycles -> res_ready_o=1, deq_valid_o=0, level_o=0, all counters and flags 0.
- Push tags 0,1,2,3 with results 16'h3C00,16'h4000,16'h4200,16'h4400 and deq_ready_i=0 -> level_o=4, res_ready_o=0; a 5th result with valid held stays unaccepted. Then set deq_ready_i=1 -> pops in order 3C00,4000,4200,4400, res_cnt_o=4.
- Push status 5'b00001 then 5'b10000 -> fflags_o=5'b10001. Assert clr_i together with an accept of status 5'b00100 -> fflags_o=5'b00100, res_cnt_o=1.
- Tag sequence 0,1,3,4 -> tag_err_o=1 after tag 3, err_cnt_o=1; tag 4 raises no new error.
- Continuous valid with deq_ready_i=1 at level 1 -> one result per cycle, level_o stays 1, first data appears exactly 1 cycle after its accept.
- Fill 3 entries, pulse rst_ni low for 1 cycle -> level_o=0, deq_valid_o=0, res_cnt_o=0.
